// File: rtl/axi_pkg.sv
// Shared AXI3 constants and the per-channel FSM state type used by the SRAM-to-AXI bridge.
package axi_pkg;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_1B    = 3'd0;
   localparam logic [2:0] SIZE_2B    = 3'd1;
   localparam logic [2:0] SIZE_4B    = 3'd2;
   localparam logic [3:0] LEN_SINGLE = 4'd0;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } ch_state_e;

endpackage

// File: rtl/axi_sram_bridge_if.sv
// AXI3 master-side bundle (AR/R/AW/W/B) connecting the bridge to the top-level AXI pins.
interface axi_sram_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);

   logic                  arvalid;
   logic                  arready;
   logic [ID_W-1:0]       arid;
   logic [ADDR_W-1:0]     araddr;
   logic [3:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic [1:0]            arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;

   logic                  rvalid;
   logic                  rready;
   logic [ID_W-1:0]       rid;
   logic [DATA_W-1:0]     rdata;
   logic [1:0]            rresp;
   logic                  rlast;

   logic                  awvalid;
   logic                  awready;
   logic [ID_W-1:0]       awid;
   logic [ADDR_W-1:0]     awaddr;
   logic [3:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic [1:0]            awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;

   logic                  wvalid;
   logic                  wready;
   logic [ID_W-1:0]       wid;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  wlast;

   logic                  bvalid;
   logic                  bready;
   logic [ID_W-1:0]       bid;
   logic [1:0]            bresp;

   modport master (
      output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
      input  arready,
      input  rvalid, rid, rdata, rresp, rlast,
      output rready,
      output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
      input  awready,
      output wvalid, wid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready
   );

   modport slave (
      input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
      output arready,
      output rvalid, rid, rdata, rresp, rlast,
      input  rready,
      input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
      output awready,
      input  wvalid, wid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready
   );

endinterface

// File: rtl/axi_bridge_arbiter.sv
// One-grant-per-cycle channel arbiter: fixed priority (lowest index) by default,
// round-robin with a last-granted pointer when AXI_BRIDGE_RR_ARB_EN is defined.
module axi_bridge_arbiter #(
   parameter int NUM_CH = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] gnt
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef AXI_BRIDGE_RR_ARB_EN
   logic [IDX_W-1:0] last_q;
   logic [IDX_W-1:0] last_d;
   logic             found;
   int               cand;

   // Search starts just past the previous winner so every channel gets a turn.
   always_comb begin
      gnt    = '0;
      last_d = last_q;
      found  = 1'b0;
      cand   = 0;
      for (int k = 1; k <= NUM_CH; k++) begin
         cand = (int'(last_q) + k) % NUM_CH;
         if (!found && req[cand]) begin
            gnt[cand] = 1'b1;
            last_d    = IDX_W'(cand);
            found     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= IDX_W'(NUM_CH - 1);
      end else begin
         last_q <= last_d;
      end
   end
`else
   logic found;
   logic unused_clk_rst;

   assign unused_clk_rst = clk ^ rst_n;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!found && req[k]) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/axi_sram_bridge.sv
// Multi-channel SRAM-style request ports to a single AXI3 master, one outstanding access per
// channel, ID = channel index. Optional round-robin arbitration via AXI_BRIDGE_RR_ARB_EN.
module axi_sram_bridge
   import axi_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
)(
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [NUM_CH-1:0]            req_valid,
   output logic [NUM_CH-1:0]            req_ready,
   input  logic [NUM_CH-1:0]            req_wr,
   input  logic [3*NUM_CH-1:0]          req_size,
   input  logic [ADDR_W*NUM_CH-1:0]     req_addr,
   input  logic [DATA_W*NUM_CH-1:0]     req_wdata,
   input  logic [(DATA_W/8)*NUM_CH-1:0] req_wstrb,
   output logic [NUM_CH-1:0]            resp_valid,
   output logic [DATA_W*NUM_CH-1:0]     resp_rdata,
   axi_sram_bridge_if.master            axi
);

   localparam int STRB_W = DATA_W / 8;

   ch_state_e         st_q    [NUM_CH];
   ch_state_e         st_d    [NUM_CH];
   logic [DATA_W-1:0] rdata_q [NUM_CH];
   logic [DATA_W-1:0] rdata_d [NUM_CH];
   logic [NUM_CH-1:0] is_wr_q, is_wr_d;
   logic              run_q, run_d;

   logic              arvalid_q, arvalid_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [2:0]        arsize_q, arsize_d;
   logic [ID_W-1:0]   arid_q, arid_d;

   logic              awvalid_q, awvalid_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [2:0]        awsize_q, awsize_d;
   logic [ID_W-1:0]   awid_q, awid_d;
   logic              wvalid_q, wvalid_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] wstrb_q, wstrb_d;

   logic [NUM_CH-1:0] elig;
   logic [NUM_CH-1:0] gnt;
   logic [NUM_CH-1:0] raw_hit;
   logic              wr_out;
   int                gnt_idx;
   logic              sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [2:0]        sel_size;
   logic [DATA_W-1:0] sel_wdata;
   logic [STRB_W-1:0] sel_wstrb;
   logic              ar_left, aw_left, w_left;
   logic              unused_resp;

   assign ar_left     = arvalid_q & ~axi.arready;
   assign aw_left     = awvalid_q & ~axi.awready;
   assign w_left      = wvalid_q & ~axi.wready;
   assign unused_resp = ^{axi.rresp, axi.rlast, axi.bresp};

   // A write is outstanding until its B beat; reads to the same word wait behind it.
   always_comb begin
      wr_out  = 1'b0;
      raw_hit = '0;
      elig    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (is_wr_q[i] && (st_q[i] == ISSUE || st_q[i] == WAIT)) begin
            wr_out = 1'b1;
         end
      end
      for (int i = 0; i < NUM_CH; i++) begin
         raw_hit[i] = wr_out &&
                      (req_addr[i*ADDR_W+2 +: ADDR_W-2] == awaddr_q[ADDR_W-1:2]);
         if (run_q && req_valid[i] && st_q[i] == IDLE) begin
            if (req_wr[i]) begin
               elig[i] = !wr_out;
            end else begin
               elig[i] = !arvalid_q && !raw_hit[i];
            end
         end
      end
   end

   axi_bridge_arbiter #(
      .NUM_CH (NUM_CH)
   ) u_arb (
      .clk   (aclk),
      .rst_n (aresetn),
      .req   (elig),
      .gnt   (gnt)
   );

   always_comb begin
      gnt_idx = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) begin
            gnt_idx = i;
         end
      end
      sel_wr    = req_wr[gnt_idx];
      sel_addr  = req_addr[gnt_idx*ADDR_W +: ADDR_W];
      sel_size  = req_size[gnt_idx*3 +: 3];
      sel_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
      sel_wstrb = req_wstrb[gnt_idx*STRB_W +: STRB_W];
   end

   // Address/data channel registers plus the per-channel IDLE/ISSUE/WAIT/RESP machines.
   always_comb begin
      run_d     = 1'b1;
      arvalid_d = arvalid_q & ~axi.arready;
      araddr_d  = araddr_q;
      arsize_d  = arsize_q;
      arid_d    = arid_q;
      awvalid_d = aw_left;
      awaddr_d  = awaddr_q;
      awsize_d  = awsize_q;
      awid_d    = awid_q;
      wvalid_d  = w_left;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      is_wr_d   = is_wr_q;
      for (int i = 0; i < NUM_CH; i++) begin
         st_d[i]    = st_q[i];
         rdata_d[i] = rdata_q[i];
      end

      if (|gnt) begin
         if (sel_wr) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = sel_addr;
            awsize_d  = sel_size;
            awid_d    = ID_W'(gnt_idx);
            wdata_d   = sel_wdata;
            wstrb_d   = sel_wstrb;
         end else begin
            arvalid_d = 1'b1;
            araddr_d  = sel_addr;
            arsize_d  = sel_size;
            arid_d    = ID_W'(gnt_idx);
         end
      end

      for (int i = 0; i < NUM_CH; i++) begin
         case (st_q[i])
            IDLE: begin
               if (gnt[i]) begin
                  st_d[i]    = ISSUE;
                  is_wr_d[i] = req_wr[i];
               end
            end
            ISSUE: begin
               if (is_wr_q[i] ? (!aw_left && !w_left) : !ar_left) begin
                  st_d[i] = WAIT;
               end
            end
            WAIT: begin
               if (!is_wr_q[i] && axi.rvalid && axi.rid == ID_W'(i)) begin
                  st_d[i]    = RESP;
                  rdata_d[i] = axi.rdata;
               end else if (is_wr_q[i] && axi.bvalid && axi.bid == ID_W'(i)) begin
                  st_d[i] = RESP;
               end
            end
            RESP: begin
               st_d[i] = IDLE;
            end
            default: begin
               st_d[i] = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i]    <= IDLE;
            rdata_q[i] <= '0;
         end
         is_wr_q   <= '0;
         run_q     <= 1'b0;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arsize_q  <= '0;
         arid_q    <= '0;
         awvalid_q <= 1'b0;
         awaddr_q  <= '0;
         awsize_q  <= '0;
         awid_q    <= '0;
         wvalid_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i]    <= st_d[i];
            rdata_q[i] <= rdata_d[i];
         end
         is_wr_q   <= is_wr_d;
         run_q     <= run_d;
         arvalid_q <= arvalid_d;
         araddr_q  <= araddr_d;
         arsize_q  <= arsize_d;
         arid_q    <= arid_d;
         awvalid_q <= awvalid_d;
         awaddr_q  <= awaddr_d;
         awsize_q  <= awsize_d;
         awid_q    <= awid_d;
         wvalid_q  <= wvalid_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
      end
   end

   always_comb begin
      resp_valid = '0;
      resp_rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         resp_valid[i]                  = (st_q[i] == RESP);
         resp_rdata[i*DATA_W +: DATA_W] = rdata_q[i];
      end
   end

   assign req_ready   = gnt;

   assign axi.arvalid = arvalid_q;
   assign axi.arid    = arid_q;
   assign axi.araddr  = araddr_q;
   assign axi.arlen   = LEN_SINGLE;
   assign axi.arsize  = arsize_q;
   assign axi.arburst = BURST_INCR;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'b0000;
   assign axi.arprot  = 3'b000;
   assign axi.rready  = run_q;

   assign axi.awvalid = awvalid_q;
   assign axi.awid    = awid_q;
   assign axi.awaddr  = awaddr_q;
   assign axi.awlen   = LEN_SINGLE;
   assign axi.awsize  = awsize_q;
   assign axi.awburst = BURST_INCR;
   assign axi.awlock  = 2'b00;
   assign axi.awcache = 4'b0000;
   assign axi.awprot  = 3'b000;

   assign axi.wvalid  = wvalid_q;
   assign axi.wid     = awid_q;
   assign axi.wdata   = wdata_q;
   assign axi.wstrb   = wstrb_q;
   assign axi.wlast   = 1'b1;
   assign axi.bready  = run_q;

endmodule

// File: doc/axi_sram_bridge.md
Name: axi_sram_bridge

Overview:
- Parametrised multi-channel bridge between simple SRAM-like request ports (instruction fetch, data load/store, future cache refill) and a single AXI3 master interface.
- Sits between the CPU core and its top-level AXI pins.
- Arbitrates up to NUM_CH channels, tags each transaction with its channel index as AXI ID, and routes responses back by ID.
- Enforces read-after-write ordering against the in-flight write.

Parameters:
- NUM_CH, 2, number of request channels (1..8); channel 0 has highest fixed priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- ID_W, 4, AXI ID width; must satisfy 2**ID_W >= NUM_CH.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_ready  out  NUM_CH  per-channel request accepted.
- req_wr  in  NUM_CH  1 = write, 0 = read.
- req_size  in  3*NUM_CH  AXI size encoding per channel.
- req_addr  in  ADDR_W*NUM_CH  byte address.
- req_wdata  in  DATA_W*NUM_CH  write data.
- req_wstrb  in  (DATA_W/8)*NUM_CH  write byte strobes.
- resp_valid  out  NUM_CH  one-cycle response pulse (read data or write done).
- resp_rdata  out  DATA_W*NUM_CH  read data, valid with resp_valid.
- AXI3 master channels ar*/r*/aw*/w*/b*: standard directions and widths; ID fields are ID_W bits.

Behaviour:
- Reset (async, aresetn low): arvalid, awvalid, wvalid, rready, bready, req_ready, resp_valid all 0; all channel-busy flags cleared; arid/awid/wid/araddr/awaddr/wdata/wstrb = 0.
- Constant outputs: arlen/awlen = 0, arburst/awburst = 2'b01, arlock/awlock = 0, arcache/awcache = 0, arprot/awprot = 0, wlast = 1, wid = awid.
- rready and bready are 1 from the first cycle after reset; responses are never back-pressured.
- Per-channel FSM: IDLE -> (req_valid & req_ready) -> ISSUE -> (addr handshake done) -> WAIT -> (matching R or B beat) -> RESP -> IDLE.
  - Each channel has at most one outstanding transaction.
  - req_ready[i] is high only in IDLE and only when channel i wins arbitration that cycle.
- Arbitration, one grant per cycle across all channels:
  - Read grant requires the AR slot to be free.
  - Write grant requires no write outstanding (global single-write limit).
- Reads:
  - Request accepted in cycle T -> arvalid high from T+1 with araddr/arsize/arid=i; held stable until arready.
  - R beat with rid=i -> resp_valid[i] and resp_rdata at the next cycle (registered), one-cycle pulse.
- Writes:
  - awvalid and wvalid both rise at T+1; each drops independently on its own ready.
  - Write completes on bvalid with bid=i -> resp_valid[i] next cycle.
- RAW hazard: a read whose addr[ADDR_W-1:2] equals the outstanding write address is not granted until that write's B beat has been received.
- Simultaneous R and B beats for different channels: both resp_valid pulses fire in the same cycle.
- R/B beat whose ID maps to a channel not in WAIT (including IDs >= NUM_CH): discarded silently.
- Reset mid-operation: all state dropped; stale post-reset responses hit a non-WAIT channel and are discarded.

Optional Feature:
- Macro AXI_BRIDGE_RR_ARB_EN.
- Defined: round-robin arbitration; the last-granted pointer advances past the winner after each grant, so a channel waits at most NUM_CH-1 grants.
- Undefined: fixed priority, lowest index wins.

Decomposition:
- Shared package axi_pkg holds:
  - AXI constants: BURST_INCR = 2'b01, SIZE_1B/2B/4B, LEN_SINGLE = 0.
  - The channel-FSM state enum (IDLE, ISSUE, WAIT, RESP).
- One sub-module, axi_bridge_arbiter: NUM_CH-wide request vector in, one-hot grant out; holds the round-robin pointer when the macro is set.

Test Plan:
- Single read: ch1 reads 0x1fc0_0000, slave returns 0xdeadbeef after 3 cycles -> arid=1, arlen=0, arburst=01; resp_valid[1] one cycle after rvalid, resp_rdata=0xdeadbeef.
- Contention: ch0 and ch1 both read in the same cycle.
  - Fixed priority -> ch0 granted first.
  - With AXI_BRIDGE_RR_ARB_EN and ch0 last granted -> ch1 granted first.
- Write with delayed ready: awready delayed 2 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3; resp_valid[0] one cycle after bvalid.
- RAW hazard: ch1 writes 0x1000, ch0 reads 0x1002 before bvalid -> no arvalid until the cycle after the B beat.
- Out-of-order response: ch0 and ch1 reads outstanding, slave returns rid=1 first -> resp_valid[1] fires before resp_valid[0], with correct data on each.
- Reset: aresetn pulled low while ch0 is in WAIT, then a stale rvalid rid=0 arrives after release -> no resp_valid; all valids 0 during reset.
